lsq_seq_ctrl: RTL

Top-level sequencer for the 2x2 least-squares fit datapath.
- Accepts a command carrying a sample-RAM base address.
- Streams N consecutive (x, y) samples from the sample RAM into the XTX and XTY accumulators.
- Waits for both accumulator results, then starts the 2x2 matrix inverter and waits for it to finish.
- Reports completion, or a timeout error, to the host.
- Does not touch data words: RAM read data goes straight to the accumulators; this block drives only address and control.

---
 rtl/lsq_seq_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/lsq_seq_ctrl.sv
// lsq_seq_ctrl: top-level sequencer for the 2x2 least-squares fit datapath.
// Takes a host command with a sample-RAM base address and streams N
// consecutive samples into the XTX/XTY accumulators. It then waits for both
// accumulator results, runs the 2x2 inverter and reports done/err to the host.
// Only address and control are driven here; RAM data goes directly to the
// accumulators.
//
// Optional build macro: LSQ_TIMEOUT_EN
//   defined   : WAIT_ACC / WAIT_INV are bounded by TIMEOUT cycles, and an
//               expired wait ends the command with err=1.
//   undefined : wait states wait indefinitely and err stays 0.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | cmd_ready high, waiting for a host command
// S_FETCH     | one RAM read per cycle, base .. base+N-1 (address wraps)
// S_WAIT_ACC  | collecting xtx_valid / xty_valid into sticky flags
// S_INV_START | single-cycle inverter start pulse
// S_WAIT_INV  | waiting for the inverter result
// S_DONE      | one-cycle done pulse, then back to idle

module lsq_seq_ctrl #(
  parameter int N       = 256,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              acc_start,
  input  logic              xtx_valid,
  input  logic              xty_valid,
  output logic              inv_start,
  input  logic              inv_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit lets the fetch counter hold N when N equals 2^ADDR_W.
  localparam int FCNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ACC  = 3'd2,
    S_INV_START = 3'd3,
    S_WAIT_INV  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] fcnt_d;
  logic              xtx_seen;
  logic              xtx_seen_d;
  logic              xty_seen;
  logic              xty_seen_d;

  // Next-cycle values of the registered outputs.
  logic              cmd_ready_d;
  logic              mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              acc_start_d;
  logic              inv_start_d;
  logic              busy_d;
  logic              done_d;
  logic              err_d;

  // High on the last cycle a wait state may spend before it gives up.
  logic              timeout_hit;

`ifdef LSQ_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_d;

  // Wait counter: restarts at 0 on entry to a wait state and counts while we stay there.
  always_comb begin
    wcnt_d = '0;
    if (((state == S_WAIT_ACC) || (state == S_WAIT_INV)) && (state_d == state)) begin
      wcnt_d = wcnt + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt_d;
    end
  end

  // The TIMEOUT-th wait cycle is the last one; a valid pulse on it still wins.
  assign timeout_hit = (wcnt == WCNT_W'(TIMEOUT - 1));
`else
  // Without the counter a wait never expires, so TIMEOUT has no effect here.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d     = state;
    fcnt_d      = fcnt;
    xtx_seen_d  = xtx_seen;
    xty_seen_d  = xty_seen;
    cmd_ready_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr;
    acc_start_d = 1'b0;
    inv_start_d = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    err_d       = err;

    unique case (state)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        if (cmd_valid && cmd_ready) begin
          state_d     = S_FETCH;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = cmd_base;
          acc_start_d = 1'b1;
          fcnt_d      = '0;
          err_d       = 1'b0;
        end
      end

      S_FETCH: begin
        // fcnt is the index of the address being presented this cycle.
        if (fcnt == FCNT_W'(N - 1)) begin
          state_d = S_WAIT_ACC;
        end else begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = mem_addr + 1'b1;
          fcnt_d      = fcnt + 1'b1;
        end
      end

      S_WAIT_ACC: begin
        // Pulses arriving this cycle count toward the exit decision.
        xtx_seen_d = xtx_seen | xtx_valid;
        xty_seen_d = xty_seen | xty_valid;
        if (xtx_seen_d && xty_seen_d) begin
          state_d     = S_INV_START;
          inv_start_d = 1'b1;
        end else if (timeout_hit) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          xtx_seen_d = 1'b0;
          xty_seen_d = 1'b0;
        end
      end

      S_INV_START: begin
        xtx_seen_d = 1'b0;
        xty_seen_d = 1'b0;
        state_d    = S_WAIT_INV;
      end

      S_WAIT_INV: begin
        if (inv_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, fetch counter and sticky result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      fcnt     <= '0;
      xtx_seen <= 1'b0;
      xty_seen <= 1'b0;
    end else begin
      state    <= state_d;
      fcnt     <= fcnt_d;
      xtx_seen <= xtx_seen_d;
      xty_seen <= xty_seen_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      acc_start <= 1'b0;
      inv_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_d;
      mem_rd_en <= mem_rd_en_d;
      mem_addr  <= mem_addr_d;
      acc_start <= acc_start_d;
      inv_start <= inv_start_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
